// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - instruction memory fetch sequencer with stall, redirect and program-load port handoff
// Owns the PC and the memory read port; hands the port to the boot loader while in LOAD.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        load_req_i,
  input  logic        load_valid_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_data_i,
  input  logic        load_done_i,
  output logic        load_grant_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o,
  output logic        if_valid_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_LOAD  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        if_valid_q, if_valid_d;

  logic [31:0] redirect_tgt;
  logic        unused_redirect_lsbs;

  assign redirect_tgt         = {redirect_pc_i[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      if_pc_q    <= 32'h0;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
    end
  end

  // Memory port is driven purely from state and inputs, so an async reset
  // (state forced to IDLE) silences it in the same instant.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    if_pc_d      = if_pc_q;
    if_valid_d   = if_valid_q;
    mem_en_o     = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = 32'h0;
    mem_wdata_o  = 32'h0;
    load_grant_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if_valid_d = 1'b0;
        state_d    = load_req_i ? ST_LOAD : ST_FETCH;
      end

      ST_FETCH, ST_HOLD: begin
        if (load_req_i) begin
          if_valid_d = 1'b0;
          state_d    = ST_LOAD;
        end else if (redirect_i) begin
          mem_en_o   = 1'b1;
          mem_addr_o = redirect_tgt;
          pc_d       = redirect_tgt + 32'd4;
          if_pc_d    = redirect_tgt;
          if_valid_d = 1'b1;
          state_d    = ST_FETCH;
        end else if (stall_i) begin
          // Memory enable low keeps its output register, and so if_instr, frozen.
          state_d = ST_HOLD;
        end else begin
          mem_en_o   = 1'b1;
          mem_addr_o = pc_q;
          pc_d       = pc_q + 32'd4;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          state_d    = ST_FETCH;
        end
      end

      ST_LOAD: begin
        load_grant_o = 1'b1;
        mem_en_o     = load_valid_i;
        mem_we_o     = load_valid_i;
        mem_addr_o   = load_addr_i;
        mem_wdata_o  = load_data_i;
        if (load_done_i) begin
          pc_d    = RESET_PC;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign if_instr_o = mem_rdata_i;
  assign if_pc_o    = if_pc_q;
  assign if_valid_o = if_valid_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - directed self-checking bench for imem_fetch_ctrl with a behavioural 8 KB memory
module tb_imem_fetch_ctrl;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        load_req;
  logic        load_valid;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        load_done;
  logic        load_grant;
  logic [31:0] mem_addr;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_valid;

  int checks;
  int failures;

  logic [31:0] mem [0:2047];

  imem_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .load_req_i    (load_req),
    .load_valid_i  (load_valid),
    .load_addr_i   (load_addr),
    .load_data_i   (load_data),
    .load_done_i   (load_done),
    .load_grant_o  (load_grant),
    .mem_addr_o    (mem_addr),
    .mem_en_o      (mem_en),
    .mem_we_o      (mem_we),
    .mem_wdata_o   (mem_wdata),
    .mem_rdata_i   (mem_rdata),
    .if_instr_o    (if_instr),
    .if_pc_o       (if_pc),
    .if_valid_o    (if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory with enable-gated output register.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[12:2]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[12:2]];
    end
  end

  task automatic test_reset;
    #1;
    checks++; if (if_valid !== 1'b0)    begin failures++; $display("FAIL rst_if_valid got=%b want=0", if_valid); end
    checks++; if (if_pc !== 32'h0)      begin failures++; $display("FAIL rst_if_pc got=%h want=0", if_pc); end
    checks++; if (load_grant !== 1'b0)  begin failures++; $display("FAIL rst_load_grant got=%b want=0", load_grant); end
    checks++; if (mem_en !== 1'b0)      begin failures++; $display("FAIL rst_mem_en got=%b want=0", mem_en); end
    checks++; if (mem_we !== 1'b0)      begin failures++; $display("FAIL rst_mem_we got=%b want=0", mem_we); end
    checks++; if (mem_addr !== 32'h0)   begin failures++; $display("FAIL rst_mem_addr got=%h want=0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0)  begin failures++; $display("FAIL rst_mem_wdata got=%h want=0", mem_wdata); end
  endtask

  task automatic test_seq_fetch;
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk); #1;
    checks++; if (mem_en !== 1'b1)     begin failures++; $display("FAIL seq_first_en got=%b want=1", mem_en); end
    checks++; if (mem_addr !== 32'h0)  begin failures++; $display("FAIL seq_first_addr got=%h want=0", mem_addr); end
    checks++; if (if_valid !== 1'b0)   begin failures++; $display("FAIL seq_first_valid got=%b want=0", if_valid); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (if_valid !== 1'b1)       begin failures++; $display("FAIL seq_valid k=%0d got=%b want=1", k, if_valid); end
      checks++; if (if_pc !== 32'(4 * k))    begin failures++; $display("FAIL seq_pc k=%0d got=%h want=%h", k, if_pc, 32'(4 * k)); end
      checks++; if (if_instr !== 32'(k))     begin failures++; $display("FAIL seq_instr k=%0d got=%h want=%h", k, if_instr, 32'(k)); end
    end
  endtask

  task automatic test_stall;
    stall = 1'b1;
    for (int j = 0; j < 3; j++) begin
      if (j > 0) @(negedge clk);
      #1;
      checks++; if (mem_en !== 1'b0)     begin failures++; $display("FAIL stall_en j=%0d got=%b want=0", j, mem_en); end
      checks++; if (if_pc !== 32'h8)     begin failures++; $display("FAIL stall_pc j=%0d got=%h want=8", j, if_pc); end
      checks++; if (if_instr !== 32'h2)  begin failures++; $display("FAIL stall_instr j=%0d got=%h want=2", j, if_instr); end
    end
    @(negedge clk); stall = 1'b0; #1;
    checks++; if (if_pc !== 32'h8)     begin failures++; $display("FAIL stall_held_pc got=%h want=8", if_pc); end
    checks++; if (mem_addr !== 32'hC)  begin failures++; $display("FAIL stall_resume_addr got=%h want=c", mem_addr); end
    @(negedge clk);
    checks++; if (if_pc !== 32'hC)     begin failures++; $display("FAIL stall_next_pc got=%h want=c", if_pc); end
    checks++; if (if_instr !== 32'h3)  begin failures++; $display("FAIL stall_next_instr got=%h want=3", if_instr); end
  endtask

  task automatic test_redirect;
    stall = 1'b1;
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h103; #1;
    checks++; if (mem_en !== 1'b1)       begin failures++; $display("FAIL redir_en got=%b want=1", mem_en); end
    checks++; if (mem_addr !== 32'h100)  begin failures++; $display("FAIL redir_addr got=%h want=100", mem_addr); end
    @(negedge clk);
    redirect = 1'b0; stall = 1'b0;
    checks++; if (if_pc !== 32'h100)     begin failures++; $display("FAIL redir_pc got=%h want=100", if_pc); end
    checks++; if (if_instr !== 32'd64)   begin failures++; $display("FAIL redir_instr got=%h want=40", if_instr); end
    checks++; if (if_valid !== 1'b1)     begin failures++; $display("FAIL redir_valid got=%b want=1", if_valid); end
    #1;
    checks++; if (mem_addr !== 32'h104)  begin failures++; $display("FAIL redir_seq_addr got=%h want=104", mem_addr); end
    @(negedge clk);
    checks++; if (if_pc !== 32'h104)     begin failures++; $display("FAIL redir_seq1_pc got=%h want=104", if_pc); end
    checks++; if (if_instr !== 32'd65)   begin failures++; $display("FAIL redir_seq1_instr got=%h want=41", if_instr); end
    @(negedge clk);
    checks++; if (if_pc !== 32'h108)     begin failures++; $display("FAIL redir_seq2_pc got=%h want=108", if_pc); end
    checks++; if (if_instr !== 32'd66)   begin failures++; $display("FAIL redir_seq2_instr got=%h want=42", if_instr); end
  endtask

  task automatic test_load;
    load_req = 1'b1; #1;
    checks++; if (mem_en !== 1'b0)      begin failures++; $display("FAIL load_req_en got=%b want=0", mem_en); end
    checks++; if (load_grant !== 1'b0)  begin failures++; $display("FAIL load_req_grant got=%b want=0", load_grant); end
    @(negedge clk);
    checks++; if (if_valid !== 1'b0)    begin failures++; $display("FAIL load_valid_drop got=%b want=0", if_valid); end
    checks++; if (load_grant !== 1'b1)  begin failures++; $display("FAIL load_grant got=%b want=1", load_grant); end
    load_req = 1'b0; load_valid = 1'b1; load_addr = 32'h0; load_data = 32'hDEADBEEF; #1;
    checks++; if (mem_we !== 1'b1)              begin failures++; $display("FAIL load_we got=%b want=1", mem_we); end
    checks++; if (mem_en !== 1'b1)              begin failures++; $display("FAIL load_en got=%b want=1", mem_en); end
    checks++; if (mem_wdata !== 32'hDEADBEEF)   begin failures++; $display("FAIL load_wdata got=%h want=deadbeef", mem_wdata); end
    @(negedge clk);
    checks++; if (load_grant !== 1'b1)  begin failures++; $display("FAIL load_stay got=%b want=1", load_grant); end
    load_addr = 32'h4; load_data = 32'h12345678; load_done = 1'b1; #1;
    checks++; if (mem_addr !== 32'h4)   begin failures++; $display("FAIL load_done_addr got=%h want=4", mem_addr); end
    checks++; if (mem_we !== 1'b1)      begin failures++; $display("FAIL load_done_we got=%b want=1", mem_we); end
    @(negedge clk);
    load_valid = 1'b0; load_done = 1'b0; load_addr = 32'h0; load_data = 32'h0;
    checks++; if (load_grant !== 1'b0)        begin failures++; $display("FAIL load_exit_grant got=%b want=0", load_grant); end
    checks++; if (mem_we !== 1'b0)            begin failures++; $display("FAIL load_exit_we got=%b want=0", mem_we); end
    checks++; if (if_valid !== 1'b0)          begin failures++; $display("FAIL load_exit_valid got=%b want=0", if_valid); end
    checks++; if (mem[0] !== 32'hDEADBEEF)    begin failures++; $display("FAIL load_word0 got=%h want=deadbeef", mem[0]); end
    checks++; if (mem[1] !== 32'h12345678)    begin failures++; $display("FAIL load_word1 got=%h want=12345678", mem[1]); end
    @(negedge clk); #1;
    checks++; if (mem_en !== 1'b1)      begin failures++; $display("FAIL load_refetch_en got=%b want=1", mem_en); end
    checks++; if (mem_addr !== 32'h0)   begin failures++; $display("FAIL load_refetch_addr got=%h want=0", mem_addr); end
    checks++; if (if_valid !== 1'b0)    begin failures++; $display("FAIL load_refetch_valid got=%b want=0", if_valid); end
    @(negedge clk);
    checks++; if (if_valid !== 1'b1)           begin failures++; $display("FAIL load_res_valid got=%b want=1", if_valid); end
    checks++; if (if_pc !== 32'h0)             begin failures++; $display("FAIL load_res_pc0 got=%h want=0", if_pc); end
    checks++; if (if_instr !== 32'hDEADBEEF)   begin failures++; $display("FAIL load_res_instr0 got=%h want=deadbeef", if_instr); end
    @(negedge clk);
    checks++; if (if_pc !== 32'h4)             begin failures++; $display("FAIL load_res_pc1 got=%h want=4", if_pc); end
    checks++; if (if_instr !== 32'h12345678)   begin failures++; $display("FAIL load_res_instr1 got=%h want=12345678", if_instr); end
  endtask

  task automatic test_wrap;
    redirect = 1'b1; redirect_pc = 32'h1FFC; #1;
    checks++; if (mem_addr !== 32'h1FFC)  begin failures++; $display("FAIL wrap_addr0 got=%h want=1ffc", mem_addr); end
    @(negedge clk);
    redirect = 1'b0;
    checks++; if (if_pc !== 32'h1FFC)     begin failures++; $display("FAIL wrap_pc0 got=%h want=1ffc", if_pc); end
    checks++; if (if_instr !== 32'd2047)  begin failures++; $display("FAIL wrap_instr0 got=%h want=7ff", if_instr); end
    #1;
    checks++; if (mem_addr !== 32'h2000)  begin failures++; $display("FAIL wrap_addr1 got=%h want=2000", mem_addr); end
    @(negedge clk);
    checks++; if (if_pc !== 32'h2000)          begin failures++; $display("FAIL wrap_pc1 got=%h want=2000", if_pc); end
    checks++; if (if_instr !== 32'hDEADBEEF)   begin failures++; $display("FAIL wrap_instr1 got=%h want=deadbeef", if_instr); end
  endtask

  task automatic test_reset_mid_load;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    checks++; if (load_grant !== 1'b1)  begin failures++; $display("FAIL rml_grant got=%b want=1", load_grant); end
    load_valid = 1'b1; load_addr = 32'h8; load_data = 32'hCAFEF00D; #1;
    checks++; if (mem_we !== 1'b1)      begin failures++; $display("FAIL rml_we_before got=%b want=1", mem_we); end
    #2; reset_n = 1'b0; #1;
    checks++; if (mem_we !== 1'b0)      begin failures++; $display("FAIL rml_we got=%b want=0", mem_we); end
    checks++; if (mem_en !== 1'b0)      begin failures++; $display("FAIL rml_en got=%b want=0", mem_en); end
    checks++; if (load_grant !== 1'b0)  begin failures++; $display("FAIL rml_grant_drop got=%b want=0", load_grant); end
    checks++; if (if_valid !== 1'b0)    begin failures++; $display("FAIL rml_valid got=%b want=0", if_valid); end
    @(negedge clk);
    checks++; if (mem[2] !== 32'h2)     begin failures++; $display("FAIL rml_no_write got=%h want=2", mem[2]); end
    load_valid = 1'b0; load_addr = 32'h0; load_data = 32'h0;
    reset_n = 1'b1;
    @(negedge clk); #1;
    checks++; if (mem_en !== 1'b1)      begin failures++; $display("FAIL rml_restart_en got=%b want=1", mem_en); end
    checks++; if (mem_addr !== 32'h0)   begin failures++; $display("FAIL rml_restart_addr got=%h want=0", mem_addr); end
    @(negedge clk);
    checks++; if (if_valid !== 1'b1)           begin failures++; $display("FAIL rml_res_valid got=%b want=1", if_valid); end
    checks++; if (if_pc !== 32'h0)             begin failures++; $display("FAIL rml_res_pc got=%h want=0", if_pc); end
    checks++; if (if_instr !== 32'hDEADBEEF)   begin failures++; $display("FAIL rml_res_instr got=%h want=deadbeef", if_instr); end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset_n     = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    load_req    = 1'b0;
    load_valid  = 1'b0;
    load_addr   = 32'h0;
    load_data   = 32'h0;
    load_done   = 1'b0;
    for (int i = 0; i < 2048; i++) mem[i] = 32'(i);

    test_reset;
    test_seq_fetch;
    test_stall;
    test_redirect;
    test_load;
    test_wrap;
    test_reset_mid_load;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
